irq_controller: RTL and testbench
=================================

Name: irq_controller

Overview:
- Priority interrupt controller that sits between peripheral interrupt lines and the CPU control path.
- Synchronises and edge-detects up to NUM_SOURCES lines, latches them as pending, and masks them.
- Picks the highest-priority request and drives the CPU's single irq line plus a 16-bit handler address for the irq PC source.
- Tracks in-service state from the CPU's IRQ-acknowledge (reset_irq) and end-of-interrupt (rti) pulses; software configures it through a small register port.

Parameters:
NUM_SOURCES, 8, number of interrupt inputs (1..16); index 0 = highest priority
VECTOR_BASE_RST, 16'h0100, reset value of the vector base register
VECTOR_SHIFT, 2, handler address = base + (id << VECTOR_SHIFT)

Ports:
clock  in  1  system clock
reset  in  1  synchronous reset, active-high
irq_lines  in  NUM_SOURCES  asynchronous peripheral requests, rising-edge triggered
cfg_write  in  1  register write strobe
cfg_addr  in  2  register select: 0 mask, 1 vector base, 2 pending (W1C), 3 in-service (RO)
cfg_wdata  in  16  write data; bits above NUM_SOURCES ignored for regs 0/2
cfg_rdata  out  16  combinational read of the register at cfg_addr, zero-extended
irq  out  1  interrupt request to control path
irq_vector  out  16  handler address; valid and stable whenever irq=1
irq_ack  in  1  one-cycle pulse from control path (its reset_irq)
irq_eoi  in  1  one-cycle pulse when the CPU completes rti

Behaviour:
- Reset: mask=0, pending=0, in_service=0, base=VECTOR_BASE_RST, sync/edge flops=0, irq=0, irq_vector=VECTOR_BASE_RST, state=IDLE.
- Input path: two-flop synchroniser per line, then a previous-value flop. A rising edge sets pending[i]. A line high at clock edge k makes pending[i] visible after edge k+2. Level-held lines set pending only once.
- candidate = pending & mask. Winner = lowest set index. No candidate means no request.
- FSM states: IDLE, ARB, ASSERT, SERVICE.
  - IDLE: candidate!=0 -> ARB.
  - ARB: latch winner into active_id; irq_vector <= base + (active_id << VECTOR_SHIFT) in 16-bit wrap-around arithmetic -> ASSERT.
  - ASSERT: irq=1; active_id and irq_vector frozen. On irq_ack: clear pending[active_id], set in_service[active_id], irq=0 -> SERVICE.
  - SERVICE: on irq_eoi, clear the in-service bit; when in_service becomes 0 -> IDLE.
- Latency: candidate appears in IDLE -> irq high 2 cycles later.
- Committed request: once in ASSERT, irq stays high until irq_ack, even if the source is masked or its pending bit is cleared by software meanwhile. The control path samples irq only between instructions, so a withdrawn request would race it.
- Simultaneous events: a hardware edge set and a clear in the same cycle (W1C or ack) -> set wins, and the bit stays pending.
- Ignored pulses: irq_ack outside ASSERT and irq_eoi outside SERVICE are ignored. irq_eoi with in_service=0 is a no-op.
- cfg writes: apply at the clock edge. A base write in ASSERT does not affect the already-latched irq_vector. Writes to reg 3 are ignored.
- Reset asserted mid-operation returns everything to reset values next edge; pending requests are dropped.

Optional Feature:
IRQ_NESTING_EN
- Defined: in SERVICE, if the winner's index is strictly lower than the lowest set in_service bit -> ARB (preemption), and ack adds a second in_service bit. irq_eoi clears the lowest-index (highest-priority) set in_service bit. Return to IDLE only when in_service==0.
- Undefined: in SERVICE, new candidates stay pending until return to IDLE. in_service is one-hot at most.

Decomposition:
- irq_ctrl_pkg:
  - irq_state_t enum {IDLE, ARB, ASSERT, SERVICE}
  - register address localparams REG_MASK/REG_BASE/REG_PEND/REG_INSERV
  - MAX_SOURCES=16
- Sub-module irq_priority_encoder: parameterised combinational lowest-index-first encoder (valid, index). It is instantiated twice: for the candidate winner, and under IRQ_NESTING_EN for the in-service priority.

Test Plan:
1. Reset, write mask=8'h04, base=16'h0200, pulse irq_lines[2] -> irq rises 5 cycles after the input edge; irq_vector=16'h0208; pending[2]=1.
2. Pending lines 5 and 1 together, mask=8'hFF -> vector for id 1 first. After ack+eoi, id 5 is served next; cfg_rdata(reg 3) reads 8'h02 during the first service.
3. In ASSERT, write mask=0 and W1C pending -> irq stays high until irq_ack, then goes low with pending=0.
4. Edge on line 3 in the same cycle as a W1C of bit 3 -> pending[3] reads 1 afterwards. Stray irq_eoi in IDLE -> no state change.
5. Nesting, line 4 in service then line 0 edge:
   - With IRQ_NESTING_EN: irq re-asserts with base+0; in_service=8'h11; first eoi clears bit 0.
   - Without it: irq stays low until eoi.
6. Assert reset while in ASSERT -> next cycle irq=0, all registers at reset values, FSM in IDLE.

Source files
------------

// File: rtl/irq_ctrl_pkg.sv
// Shared types, register map and helpers for the priority interrupt controller.
// Imported by the controller top and its testbench.
package irq_ctrl_pkg;

  localparam int MAX_SOURCES = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARB     = 2'd1,
    ASSERT  = 2'd2,
    SERVICE = 2'd3
  } irq_state_t;

  localparam logic [1:0] REG_MASK   = 2'd0;
  localparam logic [1:0] REG_BASE   = 2'd1;
  localparam logic [1:0] REG_PEND   = 2'd2;
  localparam logic [1:0] REG_INSERV = 2'd3;

  typedef struct packed {
    logic mask;
    logic base;
    logic pend;
  } cfg_wr_t;

  // Index width that stays legal for a single-source build.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic cfg_wr_t decode_write(input logic write, input logic [1:0] addr);
    cfg_wr_t w;
    w = '0;
    if (write) begin
      case (addr)
        REG_MASK: w.mask = 1'b1;
        REG_BASE: w.base = 1'b1;
        REG_PEND: w.pend = 1'b1;
        default:  ;
      endcase
    end
    return w;
  endfunction

  function automatic logic [15:0] vector_addr(input logic [15:0] base,
                                              input logic [15:0] id,
                                              input int          shift);
    return base + (id << shift);
  endfunction

endpackage

// File: rtl/irq_controller_if.sv
// Peripheral/CPU-side bundle of the interrupt controller: request lines,
// configuration register port and the irq/ack/eoi handshake.
interface irq_controller_if #(
  parameter int NUM_SOURCES = 8
);

  logic [NUM_SOURCES-1:0] irq_lines;
  logic                   cfg_write;
  logic [1:0]             cfg_addr;
  logic [15:0]            cfg_wdata;
  logic [15:0]            cfg_rdata;
  logic                   irq;
  logic [15:0]            irq_vector;
  logic                   irq_ack;
  logic                   irq_eoi;

  modport master (
    output irq_lines, cfg_write, cfg_addr, cfg_wdata, irq_ack, irq_eoi,
    input  cfg_rdata, irq, irq_vector
  );

  modport slave (
    input  irq_lines, cfg_write, cfg_addr, cfg_wdata, irq_ack, irq_eoi,
    output cfg_rdata, irq, irq_vector
  );

endinterface

// File: rtl/irq_priority_encoder.sv
// Combinational lowest-index-first priority encoder: index 0 wins.
module irq_priority_encoder #(
  parameter int WIDTH = 8,
  parameter int IDX_W = 3
) (
  input  logic [WIDTH-1:0] req_i,
  output logic             valid_o,
  output logic [IDX_W-1:0] index_o
);

  // Scan from the top so the lowest set index is written last.
  always_comb begin
    valid_o = 1'b0;
    index_o = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        valid_o = 1'b1;
        index_o = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/irq_controller.sv
// Priority interrupt controller: sync + edge detect, pending/mask, vectored irq.
// Define IRQ_NESTING_EN to allow higher-priority requests to preempt a service.
module irq_controller
  import irq_ctrl_pkg::*;
#(
  parameter int          NUM_SOURCES     = 8,
  parameter logic [15:0] VECTOR_BASE_RST = 16'h0100,
  parameter int          VECTOR_SHIFT    = 2
) (
  input  logic            clock,
  input  logic            reset,
  irq_controller_if.slave bus
);

  localparam int IDX_W = idx_width(NUM_SOURCES);

  typedef logic [NUM_SOURCES-1:0] src_t;
  typedef logic [IDX_W-1:0]       idx_t;

  src_t        sync1_q, sync2_q, prev_q, rise;
  src_t        pending_q, pending_d;
  src_t        mask_q, mask_d;
  src_t        in_service_q, in_service_d;
  src_t        pend_clr, candidate, eoi_clr, wdata_src;
  logic [15:0] base_q, base_d;
  logic [15:0] irq_vector_q, irq_vector_d;
  logic [15:0] rdata;
  irq_state_t  state_q, state_d;
  idx_t        active_id_q, active_id_d;
  idx_t        win_idx;
  logic        win_valid;
  logic        preempt;
  cfg_wr_t     wr;
  logic        unused_wdata;

  // Two-flop synchroniser followed by a previous-value flop for edge detection.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= bus.irq_lines;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign rise         = sync2_q & ~prev_q;
  assign candidate    = pending_q & mask_q;
  assign wr           = decode_write(bus.cfg_write, bus.cfg_addr);
  assign wdata_src    = bus.cfg_wdata[NUM_SOURCES-1:0];
  assign unused_wdata = ^bus.cfg_wdata;

  irq_priority_encoder #(
    .WIDTH (NUM_SOURCES),
    .IDX_W (IDX_W)
  ) u_win_enc (
    .req_i   (candidate),
    .valid_o (win_valid),
    .index_o (win_idx)
  );

`ifdef IRQ_NESTING_EN
  logic serv_valid;
  idx_t serv_idx;

  irq_priority_encoder #(
    .WIDTH (NUM_SOURCES),
    .IDX_W (IDX_W)
  ) u_serv_enc (
    .req_i   (in_service_q),
    .valid_o (serv_valid),
    .index_o (serv_idx)
  );

  // eoi retires the highest-priority service; only a strictly higher winner preempts.
  assign eoi_clr = serv_valid ? (src_t'(1) << serv_idx) : '0;
  assign preempt = win_valid && serv_valid && (win_idx < serv_idx);
`else
  assign eoi_clr = in_service_q;
  assign preempt = 1'b0;
`endif

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    state_d      = state_q;
    active_id_d  = active_id_q;
    irq_vector_d = irq_vector_q;
    mask_d       = mask_q;
    base_d       = base_q;
    in_service_d = in_service_q;
    pend_clr     = '0;

    if (wr.mask) mask_d   = wdata_src;
    if (wr.base) base_d   = bus.cfg_wdata;
    if (wr.pend) pend_clr = wdata_src;

    case (state_q)
      IDLE: begin
        if (win_valid) state_d = ARB;
      end
      ARB: begin
        if (win_valid) begin
          active_id_d  = win_idx;
          irq_vector_d = vector_addr(base_q, 16'(win_idx), VECTOR_SHIFT);
          state_d      = ASSERT;
        end else begin
          state_d = (in_service_q != '0) ? SERVICE : IDLE;
        end
      end
      ASSERT: begin
        // The request is committed: only the ack withdraws it, never mask or W1C.
        if (bus.irq_ack) begin
          pend_clr     = pend_clr | (src_t'(1) << active_id_q);
          in_service_d = in_service_q | (src_t'(1) << active_id_q);
          state_d      = SERVICE;
        end
      end
      SERVICE: begin
        if (bus.irq_eoi) in_service_d = in_service_q & ~eoi_clr;
        if (in_service_d == '0) state_d = IDLE;
        else if (preempt)       state_d = ARB;
      end
      default: state_d = IDLE;
    endcase

    // A hardware edge in the same cycle as a clear keeps the bit pending.
    pending_d = (pending_q & ~pend_clr) | rise;
  end

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (reset) begin
      state_q      <= IDLE;
      pending_q    <= '0;
      mask_q       <= '0;
      in_service_q <= '0;
      base_q       <= VECTOR_BASE_RST;
      active_id_q  <= '0;
      irq_vector_q <= VECTOR_BASE_RST;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      mask_q       <= mask_d;
      in_service_q <= in_service_d;
      base_q       <= base_d;
      active_id_q  <= active_id_d;
      irq_vector_q <= irq_vector_d;
    end
  end

  always_comb begin
    rdata = '0;
    case (bus.cfg_addr)
      REG_MASK:   rdata = 16'(mask_q);
      REG_BASE:   rdata = base_q;
      REG_PEND:   rdata = 16'(pending_q);
      REG_INSERV: rdata = 16'(in_service_q);
      default:    rdata = '0;
    endcase
  end

  assign bus.cfg_rdata  = rdata;
  assign bus.irq        = (state_q == ASSERT);
  assign bus.irq_vector = irq_vector_q;

endmodule

// File: tb/tb_irq_controller.sv
// Directed self-checking bench for irq_controller; expected vectors are queued
// when a request is driven and compared when irq rises.
module tb_irq_controller;
  import irq_ctrl_pkg::*;

  logic clk;
  logic rst;

  int n_checks = 0;
  int n_fail   = 0;
  int last_lat = 0;

  logic [15:0] exp_vec[$];

  irq_controller_if #(.NUM_SOURCES(8)) bus ();

  irq_controller #(
    .NUM_SOURCES     (8),
    .VECTOR_BASE_RST (16'h0100),
    .VECTOR_SHIFT    (2)
  ) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reg(input string tag, input logic [1:0] a, input logic [15:0] exp);
    bus.cfg_addr = a;
    #1;
    check(tag, 32'(bus.cfg_rdata), 32'(exp));
  endtask

  task automatic cfg_wr(input logic [1:0] a, input logic [15:0] d);
    bus.cfg_write = 1'b1;
    bus.cfg_addr  = a;
    bus.cfg_wdata = d;
    @(negedge clk);
    bus.cfg_write = 1'b0;
    bus.cfg_wdata = '0;
  endtask

  task automatic ack();
    bus.irq_ack = 1'b1;
    @(negedge clk);
    bus.irq_ack = 1'b0;
  endtask

  task automatic eoi();
    bus.irq_eoi = 1'b1;
    @(negedge clk);
    bus.irq_eoi = 1'b0;
  endtask

  // Wait (bounded) for irq, then pop the scoreboard and compare the vector.
  task automatic expect_irq(input string tag, input int budget);
    int          cyc;
    logic [15:0] ev;
    cyc = 0;
    while (bus.irq !== 1'b1 && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    last_lat = cyc;
    check({tag, "_irq"}, 32'(bus.irq), 32'd1);
    if (exp_vec.size() == 0) begin
      check({tag, "_sb_underflow"}, 32'(exp_vec.size()), 32'd1);
    end else begin
      ev = exp_vec.pop_front();
      check({tag, "_vec"}, 32'(bus.irq_vector), 32'(ev));
    end
  endtask

  initial begin
    int seen;
    rst           = 1'b1;
    bus.irq_lines = '0;
    bus.cfg_write = 1'b0;
    bus.cfg_addr  = REG_MASK;
    bus.cfg_wdata = '0;
    bus.irq_ack   = 1'b0;
    bus.irq_eoi   = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_irq", 32'(bus.irq), 32'd0);
    check("rst_vec", 32'(bus.irq_vector), 32'h0100);
    check_reg("rst_base", REG_BASE, 16'h0100);
    check_reg("rst_mask", REG_MASK, 16'h0000);
    rst = 1'b0;
    @(negedge clk);

    // 1: single source, latency and vector arithmetic
    cfg_wr(REG_MASK, 16'h0004);
    cfg_wr(REG_BASE, 16'h0200);
    exp_vec.push_back(16'h0208);
    bus.irq_lines[2] = 1'b1;
    expect_irq("t1", 20);
    check("t1_latency", 32'(last_lat), 32'd5);
    check_reg("t1_pend", REG_PEND, 16'h0004);
    ack();
    check("t1_irq_low", 32'(bus.irq), 32'd0);
    check_reg("t1_inserv", REG_INSERV, 16'h0004);
    check_reg("t1_pend_clr", REG_PEND, 16'h0000);
    eoi();
    check_reg("t1_inserv_clr", REG_INSERV, 16'h0000);
    repeat (6) @(negedge clk);
    check("t1_level_once", 32'(bus.irq), 32'd0);
    bus.irq_lines[2] = 1'b0;

    // 2: two simultaneous sources, lowest index first
    cfg_wr(REG_MASK, 16'h00FF);
    exp_vec.push_back(16'h0204);
    exp_vec.push_back(16'h0214);
    bus.irq_lines[5] = 1'b1;
    bus.irq_lines[1] = 1'b1;
    expect_irq("t2a", 20);
    ack();
    check_reg("t2_inserv_a", REG_INSERV, 16'h0002);
    check_reg("t2_pend_a", REG_PEND, 16'h0020);
    eoi();
    expect_irq("t2b", 20);
    ack();
    check_reg("t2_inserv_b", REG_INSERV, 16'h0020);
    eoi();
    bus.irq_lines[5] = 1'b0;
    bus.irq_lines[1] = 1'b0;
    check("t2_idle", 32'(dut.state_q), 32'(IDLE));

    // 3: committed request survives mask and W1C
    exp_vec.push_back(16'h0218);
    bus.irq_lines[6] = 1'b1;
    expect_irq("t3", 20);
    bus.irq_lines[6] = 1'b0;
    cfg_wr(REG_MASK, 16'h0000);
    cfg_wr(REG_PEND, 16'h00FF);
    check_reg("t3_pend_w1c", REG_PEND, 16'h0000);
    repeat (3) @(negedge clk);
    check("t3_irq_held", 32'(bus.irq), 32'd1);
    ack();
    check("t3_irq_low", 32'(bus.irq), 32'd0);
    check_reg("t3_pend_after", REG_PEND, 16'h0000);
    eoi();

    // 4: set wins over W1C in the same cycle; stray eoi ignored
    @(negedge clk);
    bus.irq_lines[3] = 1'b1;
    repeat (2) @(negedge clk);
    cfg_wr(REG_PEND, 16'h0008);
    check_reg("t4_set_wins", REG_PEND, 16'h0008);
    cfg_wr(REG_PEND, 16'h0008);
    check_reg("t4_w1c", REG_PEND, 16'h0000);
    eoi();
    check("t4_stray_eoi_state", 32'(dut.state_q), 32'(IDLE));
    check_reg("t4_stray_eoi_inserv", REG_INSERV, 16'h0000);
    ack();
    check("t4_stray_ack_irq", 32'(bus.irq), 32'd0);
    bus.irq_lines[3] = 1'b0;

    // 5: higher-priority request during service
    cfg_wr(REG_MASK, 16'h00FF);
    exp_vec.push_back(16'h0210);
    bus.irq_lines[4] = 1'b1;
    expect_irq("t5a", 20);
    ack();
    exp_vec.push_back(16'h0200);
    bus.irq_lines[0] = 1'b1;
`ifdef IRQ_NESTING_EN
    expect_irq("t5_nest", 20);
    ack();
    check_reg("t5_inserv_both", REG_INSERV, 16'h0011);
    eoi();
    check_reg("t5_inserv_eoi1", REG_INSERV, 16'h0010);
    check("t5_still_service", 32'(dut.state_q), 32'(SERVICE));
    eoi();
    check_reg("t5_inserv_eoi2", REG_INSERV, 16'h0000);
`else
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.irq === 1'b1) seen++;
    end
    check("t5_no_preempt", 32'(seen), 32'd0);
    check_reg("t5_pend_held", REG_PEND, 16'h0001);
    eoi();
    expect_irq("t5_after_eoi", 20);
    ack();
    check_reg("t5_inserv_0", REG_INSERV, 16'h0001);
    eoi();
`endif
    bus.irq_lines[4] = 1'b0;
    bus.irq_lines[0] = 1'b0;
    @(negedge clk);
    check("t5_idle", 32'(dut.state_q), 32'(IDLE));

    // 6: base write during ASSERT, then reset mid-operation
    exp_vec.push_back(16'h0208);
    bus.irq_lines[2] = 1'b1;
    expect_irq("t6", 20);
    cfg_wr(REG_BASE, 16'h0300);
    check("t6_vec_frozen", 32'(bus.irq_vector), 32'h0208);
    check("t6_irq_held", 32'(bus.irq), 32'd1);
    bus.irq_lines[2] = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("t6_rst_irq", 32'(bus.irq), 32'd0);
    check("t6_rst_vec", 32'(bus.irq_vector), 32'h0100);
    check("t6_rst_state", 32'(dut.state_q), 32'(IDLE));
    check_reg("t6_rst_mask", REG_MASK, 16'h0000);
    check_reg("t6_rst_base", REG_BASE, 16'h0100);
    check_reg("t6_rst_pend", REG_PEND, 16'h0000);
    check_reg("t6_rst_inserv", REG_INSERV, 16'h0000);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("t6_post_irq", 32'(bus.irq), 32'd0);

    check("sb_empty", 32'(exp_vec.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
